// File: rtl/buzzer_scheduler_if.sv
// Purpose: bundles the beep request inputs and the buzzer control outputs
//          of buzzer_scheduler into one interface.
// Signals:
//   req_kp     - keypad-done request pulse (edge-detected by the scheduler)
//   req_bt     - Bluetooth-done request pulse (edge-detected by the scheduler)
//   req_alarm  - motor-fault alarm level
//   src_sel    - 1 = keypad path active, 0 = Bluetooth path active
//   tone_en    - tone generator enable
//   tone_sel   - 0 = 440 Hz notice tone, 1 = 880 Hz alarm tone
//   active_src - 0 none, 1 keypad, 2 Bluetooth, 3 alarm
//   busy       - scheduler is not idle
// Modports: master drives requests and observes the buzzer controls,
//           slave (the scheduler) does the opposite.
interface buzzer_scheduler_if;
  logic       req_kp;
  logic       req_bt;
  logic       req_alarm;
  logic       src_sel;
  logic       tone_en;
  logic       tone_sel;
  logic [1:0] active_src;
  logic       busy;

  modport master (
    output req_kp, req_bt, req_alarm, src_sel,
    input  tone_en, tone_sel, active_src, busy
  );

  modport slave (
    input  req_kp, req_bt, req_alarm, src_sel,
    output tone_en, tone_sel, active_src, busy
  );
endinterface

// File: rtl/buzzer_scheduler.sv
// Purpose: arbitrates keypad, Bluetooth and alarm beep requests and sequences
//          the single buzzer as timed on/off patterns. Drives the enable and
//          tone select of the downstream tone generator.
// Ports:
//   clk - system clock
//   rst - synchronous active-high reset
//   bus - buzzer_scheduler_if.slave (requests in, tone controls out)
// Parameter:
//   UNIT_CYCLES - clock cycles per pattern time unit
module buzzer_scheduler #(
  parameter int UNIT_CYCLES = 10_000_000
) (
  input  logic                 clk,
  input  logic                 rst,
  buzzer_scheduler_if.slave    bus
);

  localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(UNIT_CYCLES - 1);

  localparam logic [1:0] SRC_NONE = 2'd0;
  localparam logic [1:0] SRC_KP   = 2'd1;
  localparam logic [1:0] SRC_BT   = 2'd2;
  localparam logic [1:0] SRC_ALM  = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE, S_ON, S_GAP, S_ALM_ON, S_ALM_OFF, S_GUARD
  } state_t;

  // Input stage: every request is registered once, so a request sampled at
  // edge k is acted on by the FSM at edge k+1.
  logic r_kp_s, r_kp_d, r_bt_s, r_bt_d, r_src_s, r_src_d, r_alm_s;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_unit;      // which unit of a two-unit state is running
  logic          r_step;      // Bluetooth pattern: 0 = first beep, 1 = second
  logic          r_kp_pend, r_bt_pend;
  logic          r_tone_en, r_tone_sel, r_busy;
  logic [1:0]    r_active_src;

  logic   w_src_chg, w_kp_edge, w_bt_edge, w_kp_pend, w_bt_pend;
  logic   w_unit_end, w_two_units, w_state_done, w_arb;
  logic   w_grant_kp, w_grant_bt, w_step_next;
  logic [1:0] w_src_next;
  state_t w_state_next;

  always_ff @(posedge clk) begin
    r_kp_s  <= bus.req_kp;
    r_kp_d  <= r_kp_s;
    r_bt_s  <= bus.req_bt;
    r_bt_d  <= r_bt_s;
    r_src_s <= bus.src_sel;
    r_src_d <= r_src_s;
    r_alm_s <= bus.req_alarm;
  end

  // Edges on the inactive path, or in the cycle the path switches, are dropped.
  assign w_src_chg = r_src_s ^ r_src_d;
  assign w_kp_edge = r_kp_s & ~r_kp_d &  r_src_s & ~w_src_chg;
  assign w_bt_edge = r_bt_s & ~r_bt_d & ~r_src_s & ~w_src_chg;
  // A same-cycle edge already counts as pending for arbitration.
  assign w_kp_pend = (r_kp_pend & ~w_src_chg) | w_kp_edge;
  assign w_bt_pend = (r_bt_pend & ~w_src_chg) | w_bt_edge;

  assign w_unit_end   = (r_cnt == CNT_LAST);
  assign w_two_units  = ((r_state == S_ON) && (r_active_src == SRC_KP)) ||
                        (r_state == S_ALM_ON) || (r_state == S_ALM_OFF);
  assign w_state_done = w_unit_end && (w_two_units ? r_unit : 1'b1);

  always_comb begin
    w_state_next = r_state;
    w_src_next   = r_active_src;
    w_step_next  = r_step;
    w_grant_kp   = 1'b0;
    w_grant_bt   = 1'b0;
    w_arb        = 1'b0;
    case (r_state)
      S_IDLE: w_arb = 1'b1;
      S_ON: begin
        if (r_alm_s) begin
          w_state_next = S_ALM_ON;
          w_src_next   = SRC_ALM;
        end else if (w_state_done) begin
          w_state_next = ((r_active_src == SRC_BT) && !r_step) ? S_GAP : S_GUARD;
        end
      end
      S_GAP: begin
        if (r_alm_s) begin
          w_state_next = S_ALM_ON;
          w_src_next   = SRC_ALM;
        end else if (w_state_done) begin
          w_state_next = S_ON;
          w_step_next  = 1'b1;
        end
      end
      S_ALM_ON: if (w_state_done) w_state_next = S_ALM_OFF;
      S_ALM_OFF: if (w_state_done) w_state_next = r_alm_s ? S_ALM_ON : S_GUARD;
      S_GUARD: begin
        if (r_alm_s) begin
          w_state_next = S_ALM_ON;
          w_src_next   = SRC_ALM;
        end else if (w_state_done) begin
          w_arb = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_src_next   = SRC_NONE;
      end
    endcase

    if (w_arb) begin
      if (r_alm_s) begin
        w_state_next = S_ALM_ON;
        w_src_next   = SRC_ALM;
      end else if (w_kp_pend) begin
        w_state_next = S_ON;
        w_src_next   = SRC_KP;
        w_step_next  = 1'b0;
        w_grant_kp   = 1'b1;
      end else if (w_bt_pend) begin
        w_state_next = S_ON;
        w_src_next   = SRC_BT;
        w_step_next  = 1'b0;
        w_grant_bt   = 1'b1;
      end else begin
        w_state_next = S_IDLE;
        w_src_next   = SRC_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kp_pend <= 1'b0;
      r_bt_pend <= 1'b0;
    end else begin
      r_kp_pend <= w_kp_pend & ~w_grant_kp;
      r_bt_pend <= w_bt_pend & ~w_grant_bt;
    end
  end

  // FSM state, unit timing and registered outputs (decoded from next state).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_unit       <= 1'b0;
      r_step       <= 1'b0;
      r_tone_en    <= 1'b0;
      r_tone_sel   <= 1'b0;
      r_active_src <= SRC_NONE;
      r_busy       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_step  <= w_step_next;
      if ((w_state_next != r_state) || (r_state == S_IDLE)) begin
        r_cnt  <= '0;
        r_unit <= 1'b0;
      end else if (w_unit_end) begin
        r_cnt  <= '0;
        r_unit <= ~r_unit;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_tone_en <= (w_state_next == S_ON) || (w_state_next == S_ALM_ON);
      // GUARD keeps whichever tone the preceding pattern used.
      if ((w_state_next == S_ALM_ON) || (w_state_next == S_ALM_OFF))
        r_tone_sel <= 1'b1;
      else if (w_state_next != S_GUARD)
        r_tone_sel <= 1'b0;
      r_active_src <= w_src_next;
      r_busy       <= (w_state_next != S_IDLE);
    end
  end

  assign bus.tone_en    = r_tone_en;
  assign bus.tone_sel   = r_tone_sel;
  assign bus.active_src = r_active_src;
  assign bus.busy       = r_busy;

endmodule
